mac_array_ws: RTL and testbench

- Parametrised weight-stationary N x N MAC array core: the next generation of the fixed 4x4 MAC plus output-stage datapath.
- Accepts one N-element input vector per cycle and produces the N-element vector-matrix product at a fixed latency.
- Adds three things the 4x4 datapath lacks:
  - double-buffered weights with a swap pulse;
  - a signed/unsigned mode;
  - a DEPTH-entry on-chip accumulator bank addressed by a destination tag, for K-tiling.
- Sits between the input/weight buffers and the OMEM write port.

---
 rtl/mac_pkg.sv | 23 ++
 rtl/mac_array_ws_if.sv | 39 +++
 rtl/mac_row_stage.sv | 79 +++++++
 rtl/mac_array_ws.sv | 111 +++++++++++
 tb/tb_mac_array_ws.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// Shared types and defaults for the weight-stationary MAC array.
// The tag travels with every vector so each row stage knows its weight bank and destination.
package mac_pkg;

    localparam int N_DEF     = 4;
    localparam int DW_DEF    = 8;
    localparam int AW_DEF    = 16;
    localparam int DEPTH_DEF = 16;
    localparam int DSTW_MAX  = 16;

    function automatic int dst_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // dst is stored at its widest; each user narrows it to its own DSTW.
    typedef struct packed {
        logic                valid;
        logic                bank;
        logic [DSTW_MAX-1:0] dst;
        logic                acc;
    } tag_t;

endpackage

// File: rtl/mac_array_ws_if.sv
// Bus between the input/weight buffers and the MAC array core, and from the core to OMEM.
interface mac_array_ws_if
    import mac_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF
);
    localparam int DSTW = dst_w(DEPTH);
    localparam int RW   = $clog2(N);

    logic            W_LOAD;
    logic [RW-1:0]   W_ROW;
    logic [N*DW-1:0] W_DATA;
    logic            W_SWAP;
    logic            I_VALID;
    logic [N*DW-1:0] I_DATA;
    logic [DSTW-1:0] I_DST;
    logic            I_ACC;
    logic            SIGNED;
    logic            CLR;
    logic            O_VALID;
    logic [DSTW-1:0] O_DST;
    logic [N*AW-1:0] O_DATA;

    // Handshake: I_VALID marks a vector in that cycle and is always accepted (no ready);
    // O_VALID is high exactly in the cycles an entry is written, O_DST/O_DATA hold otherwise.
    modport master (
        output W_LOAD, W_ROW, W_DATA, W_SWAP, I_VALID, I_DATA, I_DST, I_ACC, SIGNED, CLR,
        input  O_VALID, O_DST, O_DATA
    );

    modport slave (
        input  W_LOAD, W_ROW, W_DATA, W_SWAP, I_VALID, I_DATA, I_DST, I_ACC, SIGNED, CLR,
        output O_VALID, O_DST, O_DATA
    );

endinterface

// File: rtl/mac_row_stage.sv
// One row of the array: delays x[K] by K cycles, adds x[K]*W[K][c] into every column psum,
// and passes the tag along so the bank choice follows the vector.
module mac_row_stage
    import mac_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int K  = 0
)
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_signed,
    input  logic [DW-1:0]   i_x,
    input  tag_t            i_tag,
    input  logic [N*DW-1:0] i_w0,
    input  logic [N*DW-1:0] i_w1,
    input  logic [N*AW-1:0] i_psum,
    output tag_t            o_tag,
    output logic [N*AW-1:0] o_psum
);
    logic [DW-1:0]   w_x;
    logic [N*DW-1:0] w_wrow;
    logic [DW-1:0]   w_wel;
    logic [2*DW-1:0] w_xe;
    logic [2*DW-1:0] w_we;
    logic [2*DW-1:0] w_prod;
    logic [AW-1:0]   w_ext;
    logic [N*AW-1:0] w_psum_next;

    if (K == 0) begin : g_direct
        assign w_x = i_x;
    end else begin : g_skew
        logic [DW-1:0] r_skew [K];

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                for (int j = 0; j < K; j++) r_skew[j] <= '0;
            end else begin
                r_skew[0] <= i_x;
                for (int j = 1; j < K; j++) r_skew[j] <= r_skew[j-1];
            end
        end

        assign w_x = r_skew[K-1];
    end

    assign w_wrow = i_tag.bank ? i_w1 : i_w0;

    // Low 2*DW bits of the product of extended operands equal the true signed/unsigned product.
    always_comb begin
        w_wel       = '0;
        w_xe        = '0;
        w_we        = '0;
        w_prod      = '0;
        w_ext       = '0;
        w_psum_next = '0;
        for (int c = 0; c < N; c++) begin
            w_wel  = w_wrow[c*DW +: DW];
            w_xe   = i_signed ? {{DW{w_x[DW-1]}}, w_x} : {{DW{1'b0}}, w_x};
            w_we   = i_signed ? {{DW{w_wel[DW-1]}}, w_wel} : {{DW{1'b0}}, w_wel};
            w_prod = w_xe * w_we;
            w_ext  = i_signed ? AW'($signed(w_prod)) : AW'(w_prod);
            w_psum_next[c*AW +: AW] = i_psum[c*AW +: AW] + w_ext;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_tag  <= '0;
            o_psum <= '0;
        end else begin
            o_tag  <= i_tag;
            o_psum <= w_psum_next;
        end
    end

endmodule

// File: rtl/mac_array_ws.sv
// Weight-stationary N x N MAC array: double-buffered weights, N row stages, then an
// accumulate stage that updates a DEPTH-entry bank addressed by the vector's destination tag.
module mac_array_ws
    import mac_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF
)
(
    input  logic          CLK,
    input  logic          RSTN,
    mac_array_ws_if.slave bus
);
    localparam int DSTW = dst_w(DEPTH);

    logic [N*DW-1:0] r_w0 [N];
    logic [N*DW-1:0] r_w1 [N];
    logic            r_active;
    tag_t            w_tag_in;
    tag_t            w_tag [N];
    logic [N*AW-1:0] w_psum [N];
    logic [DSTW-1:0] w_dst;
    logic [N*AW-1:0] w_new;
    logic [N*AW-1:0] r_acc [DEPTH];
    logic            r_o_valid;
    logic [DSTW-1:0] r_o_dst;
    logic [N*AW-1:0] r_o_data;

    // A load always targets the pre-swap shadow, so a same-cycle load+swap lands in the new active bank.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_active <= 1'b0;
            for (int k = 0; k < N; k++) begin
                r_w0[k] <= '0;
                r_w1[k] <= '0;
            end
        end else begin
            if (bus.W_SWAP) r_active <= ~r_active;
            if (bus.W_LOAD) begin
                if (r_active) r_w0[bus.W_ROW] <= bus.W_DATA;
                else          r_w1[bus.W_ROW] <= bus.W_DATA;
            end
        end
    end

    assign w_tag_in = '{valid: bus.I_VALID, bank: r_active,
                        dst: DSTW_MAX'(bus.I_DST), acc: bus.I_ACC};

    for (genvar k = 0; k < N; k++) begin : g_row
        tag_t            w_tin;
        logic [N*AW-1:0] w_pin;

        if (k == 0) begin : g_first
            assign w_tin = w_tag_in;
            assign w_pin = '0;
        end else begin : g_chain
            assign w_tin = w_tag[k-1];
            assign w_pin = w_psum[k-1];
        end

        mac_row_stage #(.N(N), .DW(DW), .AW(AW), .K(k)) u_row (
            .i_clk    (CLK),
            .i_rst_n  (RSTN),
            .i_signed (bus.SIGNED),
            .i_x      (bus.I_DATA[k*DW +: DW]),
            .i_tag    (w_tin),
            .i_w0     (r_w0[k]),
            .i_w1     (r_w1[k]),
            .i_psum   (w_pin),
            .o_tag    (w_tag[k]),
            .o_psum   (w_psum[k])
        );
    end

    assign w_dst = DSTW'(w_tag[N-1].dst);

    always_comb begin
        w_new = w_psum[N-1];
        if (w_tag[N-1].acc) begin
            for (int c = 0; c < N; c++)
                w_new[c*AW +: AW] = r_acc[w_dst][c*AW +: AW] + w_psum[N-1][c*AW +: AW];
        end
    end

    // The bank read is a plain register, so a write lands in time for the next cycle's read.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int d = 0; d < DEPTH; d++) r_acc[d] <= '0;
            r_o_valid <= 1'b0;
            r_o_dst   <= '0;
            r_o_data  <= '0;
        end else begin
            if (bus.CLR) begin
                for (int d = 0; d < DEPTH; d++) r_acc[d] <= '0;
            end
            if (w_tag[N-1].valid) begin
                r_acc[w_dst] <= w_new;
                r_o_data     <= w_new;
                r_o_dst      <= w_dst;
            end
            r_o_valid <= w_tag[N-1].valid;
        end
    end

    assign bus.O_VALID = r_o_valid;
    assign bus.O_DST   = r_o_dst;
    assign bus.O_DATA  = r_o_data;

endmodule

// File: tb/tb_mac_array_ws.sv
// Bench for mac_array_ws: directed vectors, an arithmetic reference model checked every cycle,
// and literal expectations at the points where results are due.
module tb_mac_array_ws;
    import mac_pkg::*;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int AW    = 16;
    localparam int DEPTH = 16;
    localparam int DSTW  = 4;
    localparam int OW    = N * AW;
    localparam int QW    = 32 + DSTW + 1 + OW;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    mac_array_ws_if #(.N(N), .DW(DW), .AW(AW), .DEPTH(DEPTH)) bus();

    mac_array_ws #(.N(N), .DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .CLK  (clk),
        .RSTN (rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // reference model state
    logic [DW-1:0]   mw [2][N][N];
    int              mact;
    logic [AW-1:0]   mbank [DEPTH][N];
    logic [QW-1:0]   exp_q [$];
    logic            exp_valid;
    logic [DSTW-1:0] exp_dst;
    logic [OW-1:0]   exp_data;
    bit              prev_clr;
    logic [QW-1:0]   q_e;
    logic [DSTW-1:0] q_dst;
    logic [AW-1:0]   q_col;

    task automatic check(input string name, input logic [OW-1:0] got, input logic [OW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic clear_bank();
        for (int d = 0; d < DEPTH; d++)
            for (int c = 0; c < N; c++) mbank[d][c] = '0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        mact      = 0;
        prev_clr  = 1'b0;
        exp_valid = 1'b0;
        exp_dst   = '0;
        exp_data  = '0;
        clear_bank();
        for (int b = 0; b < 2; b++)
            for (int k = 0; k < N; k++)
                for (int c = 0; c < N; c++) mw[b][k][c] = '0;
    endtask

    // Column c = sum over k of x[k]*W[k][c], operands read as signed or unsigned, taken mod 2^AW.
    function automatic logic [OW-1:0] model_sum(input logic [N*DW-1:0] x, input int bank, input bit sgn);
        logic [OW-1:0] r;
        longint        s;
        longint        xv;
        longint        wv;
        logic [63:0]   su;
        r = '0;
        for (int c = 0; c < N; c++) begin
            s = 0;
            for (int k = 0; k < N; k++) begin
                xv = sgn ? longint'($signed(x[k*DW +: DW])) : longint'(x[k*DW +: DW]);
                wv = sgn ? longint'($signed(mw[bank][k][c])) : longint'(mw[bank][k][c]);
                s  = s + xv * wv;
            end
            su = s;
            r[c*AW +: AW] = su[AW-1:0];
        end
        return r;
    endfunction

    // Compare process: outputs in cycle c reflect vectors whose I_VALID cycle was c-N-1.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            exp_valid = 1'b0;
            if (exp_q.size() > 0 && int'(exp_q[0][QW-1 -: 32]) == cyc) begin
                q_e   = exp_q.pop_front();
                q_dst = q_e[OW+1 +: DSTW];
                for (int c = 0; c < N; c++) begin
                    q_col = q_e[c*AW +: AW];
                    if (q_e[OW]) q_col = q_col + mbank[q_dst][c];
                    exp_data[c*AW +: AW] = q_col;
                end
                if (prev_clr) clear_bank();
                for (int c = 0; c < N; c++) mbank[q_dst][c] = exp_data[c*AW +: AW];
                exp_dst   = q_dst;
                exp_valid = 1'b1;
            end else if (prev_clr) begin
                clear_bank();
            end
            prev_clr = bus.CLR;
            if (bus.I_VALID)
                exp_q.push_back({32'(cyc + N + 1), bus.I_DST, bus.I_ACC,
                                 model_sum(bus.I_DATA, mact, bus.SIGNED)});
            if (bus.W_LOAD)
                for (int c = 0; c < N; c++) mw[mact ^ 1][bus.W_ROW][c] = bus.W_DATA[c*DW +: DW];
            if (bus.W_SWAP) mact = 1 - mact;
        end
        check("model_o_valid", OW'(bus.O_VALID), OW'(exp_valid));
        check("model_o_dst", OW'(bus.O_DST), OW'(exp_dst));
        check("model_o_data", bus.O_DATA, exp_data);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [N*DW-1:0] x, input int dst, input bit acc);
        bus.I_VALID = 1'b1;
        bus.I_DATA  = x;
        bus.I_DST   = DSTW'(dst);
        bus.I_ACC   = acc;
        tick(1);
        bus.I_VALID = 1'b0;
        bus.I_ACC   = 1'b0;
    endtask

    task automatic load_row(input int row, input logic [N*DW-1:0] d, input bit swap);
        bus.W_LOAD = 1'b1;
        bus.W_ROW  = 2'(row);
        bus.W_DATA = d;
        bus.W_SWAP = swap;
        tick(1);
        bus.W_LOAD = 1'b0;
        bus.W_SWAP = 1'b0;
    endtask

    task automatic swap_only();
        bus.W_SWAP = 1'b1;
        tick(1);
        bus.W_SWAP = 1'b0;
    endtask

    task automatic load_diag(input int v);
        logic [N*DW-1:0] d;
        for (int k = 0; k < N; k++) begin
            d = '0;
            d[k*DW +: DW] = DW'(v);
            load_row(k, d, 1'b0);
        end
    endtask

    task automatic load_all(input logic [N*DW-1:0] d);
        for (int k = 0; k < N; k++) load_row(k, d, 1'b0);
    endtask

    task automatic expect_out(input string name, input int dst, input logic [OW-1:0] data);
        check({name, "_valid"}, OW'(bus.O_VALID), OW'(1'b1));
        check({name, "_dst"}, OW'(bus.O_DST), OW'(dst));
        check({name, "_data"}, bus.O_DATA, data);
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: run still active at %0t, expected finish much earlier", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    localparam logic [N*DW-1:0] X1234 = 32'h0403_0201;

    initial begin
        rst_n       = 1'b0;
        bus.W_LOAD  = 1'b0;
        bus.W_ROW   = '0;
        bus.W_DATA  = '0;
        bus.W_SWAP  = 1'b0;
        bus.I_VALID = 1'b0;
        bus.I_DATA  = '0;
        bus.I_DST   = '0;
        bus.I_ACC   = 1'b0;
        bus.SIGNED  = 1'b0;
        bus.CLR     = 1'b0;
        tick(3);
        check("reset_o_valid", OW'(bus.O_VALID), OW'(1'b0));
        check("reset_o_data", bus.O_DATA, 64'h0);
        rst_n = 1'b1;
        tick(2);

        // identity weights, unsigned
        load_diag(1);
        swap_only();
        issue(X1234, 3, 1'b0);
        tick(N);
        expect_out("identity", 3, 64'h0004_0003_0002_0001);

        // all 0xFF, signed then unsigned
        load_all(32'hFFFF_FFFF);
        swap_only();
        bus.SIGNED = 1'b1;
        issue(32'hFFFF_FFFF, 0, 1'b0);
        tick(N);
        expect_out("ff_signed", 0, 64'h0004_0004_0004_0004);
        tick(2);
        bus.SIGNED = 1'b0;
        issue(32'hFFFF_FFFF, 1, 1'b0);
        tick(N);
        expect_out("ff_unsigned", 1, 64'hF804_F804_F804_F804);

        // back-to-back accumulation into one entry
        load_all(32'h0101_0101);
        swap_only();
        issue(32'h0101_0101, 5, 1'b0);
        issue(32'h0101_0101, 5, 1'b1);
        issue(32'h0101_0101, 5, 1'b1);
        tick(2);
        expect_out("acc_first", 5, 64'h0004_0004_0004_0004);
        tick(1);
        expect_out("acc_second", 5, 64'h0008_0008_0008_0008);
        tick(1);
        expect_out("acc_third", 5, 64'h000C_000C_000C_000C);

        // swap while a vector is in flight
        load_diag(1);
        swap_only();
        load_diag(2);
        issue(X1234, 4, 1'b0);
        swap_only();
        issue(X1234, 6, 1'b0);
        tick(2);
        expect_out("bank_bound_old", 4, 64'h0004_0003_0002_0001);
        tick(2);
        expect_out("bank_bound_new", 6, 64'h0008_0006_0004_0002);

        // load and swap in one cycle: write goes to the bank becoming active
        load_row(0, 32'h0000_0003, 1'b1);
        issue(X1234, 7, 1'b0);
        tick(N);
        expect_out("load_swap", 7, 64'h0004_0003_0002_0003);

        // clear coinciding with an accumulate write
        issue(32'h0000_0700, 2, 1'b0);
        tick(3);
        bus.CLR = 1'b1;
        tick(1);
        bus.CLR = 1'b0;
        expect_out("clr_write", 2, 64'h0000_0000_0007_0000);
        issue(X1234, 5, 1'b1);
        tick(N);
        expect_out("clr_other_entry", 5, 64'h0004_0003_0002_0003);
        issue(X1234, 1, 1'b1);
        tick(N);
        expect_out("clr_dst1", 1, 64'h0004_0003_0002_0003);
        issue(32'h0000_0100, 2, 1'b1);
        tick(N);
        expect_out("clr_kept", 2, 64'h0000_0000_0008_0000);

        // reset with vectors in flight
        issue(X1234, 3, 1'b1);
        issue(X1234, 4, 1'b1);
        issue(X1234, 6, 1'b1);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(N + 3);
        check("post_reset_valid", OW'(bus.O_VALID), OW'(1'b0));
        check("post_reset_data", bus.O_DATA, 64'h0);
        check("post_reset_dst", OW'(bus.O_DST), OW'(0));
        load_diag(1);
        swap_only();
        issue(X1234, 3, 1'b1);
        tick(N);
        expect_out("post_reset_acc", 3, 64'h0004_0003_0002_0001);

        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
